hline_motion_ctrl: RTL

//  Upstream motion controller for the horizontal-line Y-coordinate counter chain.

---
 rtl/hline_motion_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hline_motion_ctrl.sv
// hline_motion_ctrl
//   Motion controller that sits in front of the loadable up/down counter
//   holding the horizontal line's Y coordinate. It turns the per-frame tick,
//   the user controls and the counter's limit flags into one-cycle UP/DW/LD
//   strobes. It covers start/load, speed division, pause with manual nudge,
//   and either bounce or hold behaviour at the limits.
//
// Handshake: there is no valid/ready pair. Every control input is sampled on
//   the rising edge of clk. Each strobe output is a registered pulse that is
//   high for exactly one cycle. That cycle is the one after the causing input
//   was sampled. The counter consumes a strobe in the cycle it is high.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   frame      one-cycle tick per video frame
//   start      pulse: load the counter and run
//   stop       pulse: return to IDLE
//   pause      level: freeze motion while running
//   nudge_up   pulse: single up step while paused
//   nudge_dn   pulse: single down step while paused
//   rate       step every rate+1 frames
//   at_top     counter at upper limit
//   at_bottom  counter at lower limit
//   UP/DW/LD   increment / decrement / load strobes
//   dir        current direction (1 = up)
//   moving     high while in RUN
//   bounces    saturating count of reversals since the last load
//   dbg_state  current FSM state (IDLE=0, LOAD=1, RUN=2, PAUSE=3)
module hline_motion_ctrl #(
  parameter int RATE_W = 4,
  parameter int BNC_W  = 8,
  parameter bit BOUNCE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              nudge_up,
  input  logic              nudge_dn,
  input  logic [RATE_W-1:0] rate,
  input  logic              at_top,
  input  logic              at_bottom,
  output logic              UP,
  output logic              DW,
  output logic              LD,
  output logic              dir,
  output logic              moving,
  output logic [BNC_W-1:0]  bounces,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                up_q, up_d;
  logic                dw_q, dw_d;
  logic                ld_q, ld_d;
  logic                dir_q, dir_d;
  logic                moving_q, moving_d;
  logic [RATE_W-1:0]   div_q, div_d;
  logic [BNC_W-1:0]    bnc_q, bnc_d;
  logic [BNC_W-1:0]    bnc_inc;

  assign bnc_inc = (bnc_q == {BNC_W{1'b1}}) ? bnc_q : bnc_q + BNC_W'(1);

  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dw_d    = 1'b0;
    ld_d    = 1'b0;
    dir_d   = dir_q;
    div_d   = div_q;
    bnc_d   = bnc_q;
    if (stop) begin
      // Stop wins over everything. Any step due this cycle is dropped.
      // Direction and the bounce count are kept.
      state_d = S_IDLE;
    end else if (start) begin
      // Loading also re-arms direction, the divider and the bounce count.
      // Because this happens on entry, the LOAD cycle already shows them.
      state_d = S_LOAD;
      ld_d    = 1'b1;
      dir_d   = 1'b1;
      div_d   = '0;
      bnc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_LOAD:  state_d = S_RUN;
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (frame) begin
            if (div_q == rate) begin
              div_d = '0;
              if (!(at_top && at_bottom)) begin
                if (dir_q) begin
                  if (!at_top) begin
                    up_d = 1'b1;
                  end else if (BOUNCE) begin
                    dir_d = 1'b0;
                    dw_d  = 1'b1;
                    bnc_d = bnc_inc;
                  end
                end else begin
                  if (!at_bottom) begin
                    dw_d = 1'b1;
                  end else if (BOUNCE) begin
                    dir_d = 1'b1;
                    up_d  = 1'b1;
                    bnc_d = bnc_inc;
                  end
                end
              end
            end else begin
              div_d = div_q + RATE_W'(1);
            end
          end
        end
        S_PAUSE: begin
          if (!pause) state_d = S_RUN;
          // Nudges are honoured only while pause is still held. This keeps a
          // nudge strobe out of the first RUN cycle. The up_q/dw_q guard
          // stops back-to-back nudges from giving a two-cycle strobe.
          if (pause && (nudge_up ^ nudge_dn) && !up_q && !dw_q) begin
            if (nudge_up && !at_top)    up_d = 1'b1;
            if (nudge_dn && !at_bottom) dw_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    moving_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      up_q     <= 1'b0;
      dw_q     <= 1'b0;
      ld_q     <= 1'b0;
      dir_q    <= 1'b1;
      moving_q <= 1'b0;
      div_q    <= '0;
      bnc_q    <= '0;
    end else begin
      state_q  <= state_d;
      up_q     <= up_d;
      dw_q     <= dw_d;
      ld_q     <= ld_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      div_q    <= div_d;
      bnc_q    <= bnc_d;
    end
  end

  assign UP        = up_q;
  assign DW        = dw_q;
  assign LD        = ld_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign bounces   = bnc_q;
  assign dbg_state = state_q;

endmodule
